// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: shares one I2C byte engine between two requesters.
// Round-robin grant, lock-held multi-byte ownership, per-byte timeout.
`timescale 1ns/1ps
module i2c_bus_arbiter #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd2_000_000,
  parameter int          CMD_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_req,
  input  logic             r0_lock,
  input  logic [CMD_W-1:0] r0_cmd,
  input  logic [7:0]       r0_din,
  output logic             r0_done,
  output logic             r0_err,
  input  logic             r1_req,
  input  logic             r1_lock,
  input  logic [CMD_W-1:0] r1_cmd,
  input  logic [7:0]       r1_din,
  output logic             r1_done,
  output logic             r1_err,
  output logic [7:0]       rd_dout,
  output logic             rd_vld,
  output logic             owner,
  output logic             busy,
  output logic             m_trans_req,
  output logic [CMD_W-1:0] m_trans_cmd,
  output logic [7:0]       m_wr_din,
  input  logic             m_trans_done,
  input  logic [7:0]       m_rd_dout,
  input  logic             m_rd_dout_vld
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, HOLD, LOCKED
  } state_t;

  state_t      state, state_n;
  logic        last_owner;
  logic [23:0] cnt;
  logic        rd_pend;
  logic        grant;
  logic        gnt_idx;
  logic        release_own;
  logic        own_req;
  logic        own_lock;
  logic        timeout;

  assign own_req  = owner ? r1_req  : r0_req;
  assign own_lock = owner ? r1_lock : r0_lock;

  // a done arriving on the last allowed cycle beats the watchdog
  assign timeout = (state == WAIT) && !m_trans_done &&
                   (cnt == TIMEOUT_CYC - 24'd1);

  assign busy        = (state != IDLE);
  assign m_trans_req = (state == ISSUE);
  assign r0_done     = (state == HOLD) && !owner;
  assign r1_done     = (state == HOLD) &&  owner;
  assign r0_err      = timeout && !owner;
  assign r1_err      = timeout &&  owner;
  assign rd_vld      = (state == HOLD) && rd_pend;

  // next-state: grant, byte handshake, lock hold and release
  always_comb begin
    state_n     = state;
    grant       = 1'b0;
    gnt_idx     = owner;
    release_own = 1'b0;
    unique case (state)
      IDLE: begin
        if (r0_req || r1_req) begin
          grant   = 1'b1;
          gnt_idx = (r0_req && r1_req) ? ~last_owner : r1_req;
          state_n = ISSUE;
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (m_trans_done) begin
          state_n = HOLD;
        end else if (timeout) begin
          state_n     = IDLE;
          release_own = 1'b1;
        end
      end
      HOLD: begin
        if (own_lock) begin
          state_n = LOCKED;
        end else begin
          state_n     = IDLE;
          release_own = 1'b1;
        end
      end
      LOCKED: begin
        if (own_req) begin
          grant   = 1'b1;
          state_n = ISSUE;
        end else if (!own_lock) begin
          state_n     = IDLE;
          release_own = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state, ownership, latched command/data, watchdog and read capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_owner  <= 1'b1;
      cnt         <= '0;
      rd_pend     <= 1'b0;
      m_trans_cmd <= '0;
      m_wr_din    <= '0;
      rd_dout     <= '0;
    end else begin
      state <= state_n;
      if (grant) begin
        owner       <= gnt_idx;
        m_trans_cmd <= gnt_idx ? r1_cmd : r0_cmd;
        m_wr_din    <= gnt_idx ? r1_din : r0_din;
      end
      if (release_own) begin
        last_owner <= owner;
      end
      if (state == ISSUE) begin
        cnt     <= '0;
        rd_pend <= 1'b0;
      end else if (state == WAIT) begin
        cnt <= cnt + 24'd1;
        if (m_rd_dout_vld) begin
          rd_dout <= m_rd_dout;
          rd_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: directed plus randomized checks of the arbiter
// against a transaction-level model of grant order and handshake timing.
`timescale 1ns/1ps
module tb_i2c_bus_arbiter;

  localparam int CMD_W = 4;
  localparam int TO    = 100;

  logic             clk;
  logic             rst;
  logic             r0_req, r0_lock, r1_req, r1_lock;
  logic [CMD_W-1:0] r0_cmd, r1_cmd;
  logic [7:0]       r0_din, r1_din;
  logic             r0_done, r0_err, r1_done, r1_err;
  logic [7:0]       rd_dout;
  logic             rd_vld, owner, busy, m_trans_req;
  logic [CMD_W-1:0] m_trans_cmd;
  logic [7:0]       m_wr_din;
  logic             m_trans_done, m_rd_dout_vld;
  logic [7:0]       m_rd_dout;
  logic [1:0]       dn, er;

  int checks   = 0;
  int failures = 0;
  bit last_srv;

  assign dn = {r1_done, r0_done};
  assign er = {r1_err, r0_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  i2c_bus_arbiter #(
    .TIMEOUT_CYC(24'd100),
    .CMD_W(CMD_W)
  ) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_lock(r0_lock), .r0_cmd(r0_cmd),
    .r0_din(r0_din), .r0_done(r0_done), .r0_err(r0_err),
    .r1_req(r1_req), .r1_lock(r1_lock), .r1_cmd(r1_cmd),
    .r1_din(r1_din), .r1_done(r1_done), .r1_err(r1_err),
    .rd_dout(rd_dout), .rd_vld(rd_vld),
    .owner(owner), .busy(busy),
    .m_trans_req(m_trans_req), .m_trans_cmd(m_trans_cmd),
    .m_wr_din(m_wr_din), .m_trans_done(m_trans_done),
    .m_rd_dout(m_rd_dout), .m_rd_dout_vld(m_rd_dout_vld)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // inputs change 1 ns after the edge, outputs are read 1 ns later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit w, input bit v);
    if (w) r1_req = v;
    else   r0_req = v;
  endtask

  // round-robin rule: a lone requester wins; on a tie the one not
  // served last wins
  function automatic bit pick(input bit [1:0] p, input bit last);
    if (p == 2'b11) return !last;
    return p[1];
  endfunction

  task automatic issue(input bit w, input logic [3:0] cmd,
                       input logic [7:0] din, input int exp_n,
                       input string tag);
    int n    = 0;
    bit seen = 0;
    for (int i = 1; i <= 12 && !seen; i++) begin
      cyc();
      #1;
      if (m_trans_req === 1'b1) begin
        seen = 1;
        n    = i;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, 32'(n), 32'(exp_n));
    chk({tag, "_owner"}, 32'(owner), 32'(w));
    chk({tag, "_cmd"}, 32'(m_trans_cmd), 32'(cmd));
    chk({tag, "_din"}, 32'(m_wr_din), 32'(din));
  endtask

  // engine answers k cycles after the request; k > TO means never
  task automatic serve(input bit w, input int k, input bit rd,
                       input logic [7:0] data, input string tag);
    int lim = (k > TO) ? TO : k;
    for (int i = 1; i <= lim; i++) begin
      cyc();
      if (i == k) begin
        m_trans_done  = 1'b1;
        m_rd_dout_vld = rd;
        m_rd_dout     = data;
      end
      #1;
      chk({tag, "_noreq"}, 32'(m_trans_req), 32'd0);
      if (i == lim) begin
        chk({tag, "_err_own"}, 32'(er[w]), 32'(k > TO));
        chk({tag, "_err_oth"}, 32'(er[!w]), 32'd0);
        chk({tag, "_busy_w"}, 32'(busy), 32'd1);
      end
    end
    if (k <= TO) begin
      cyc();
      m_trans_done  = 1'b0;
      m_rd_dout_vld = 1'b0;
      m_rd_dout     = 8'($urandom);
      #1;
      chk({tag, "_done_own"}, 32'(dn[w]), 32'd1);
      chk({tag, "_done_oth"}, 32'(dn[!w]), 32'd0);
      chk({tag, "_rdvld"}, 32'(rd_vld), 32'(rd));
      chk({tag, "_err_h"}, 32'(er), 32'd0);
      if (rd) chk({tag, "_rdout"}, 32'(rd_dout), 32'(data));
    end
    last_srv = w;
  endtask

  task automatic finish_txn(input bit w, input string tag);
    cyc();
    set_req(w, 1'b0);
    #1;
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_nodone"}, 32'(dn), 32'd0);
  endtask

  initial begin
    logic [7:0] bytes [4];
    bytes[0] = 8'h78;
    bytes[1] = 8'h30;
    bytes[2] = 8'h08;
    bytes[3] = 8'h82;

    rst = 1'b1;
    {r0_req, r0_lock, r1_req, r1_lock} = '0;
    r0_cmd = '0; r1_cmd = '0; r0_din = '0; r1_din = '0;
    m_trans_done = 1'b0; m_rd_dout_vld = 1'b0; m_rd_dout = '0;
    last_srv = 1'b1;

    cyc();
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(m_trans_req), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_cmd", 32'(m_trans_cmd), 32'd0);
    chk("rst_din", 32'(m_wr_din), 32'd0);
    chk("rst_rdout", 32'(rd_dout), 32'd0);
    chk("rst_flags", 32'({dn, er, rd_vld}), 32'd0);
    cyc();
    rst = 1'b0;

    // tie straight after reset: r0 first, then r1
    cyc();
    r0_cmd = 4'h1; r0_din = 8'hA0; r1_cmd = 4'h2; r1_din = 8'hB1;
    r0_req = 1'b1; r1_req = 1'b1;
    issue(0, 4'h1, 8'hA0, 1, "tie1a");
    serve(0, 5, 0, 8'h00, "tie1a");
    finish_txn(0, "tie1a");
    issue(1, 4'h2, 8'hB1, 1, "tie1b");
    serve(1, 4, 1, 8'h3C, "tie1b");
    finish_txn(1, "tie1b");

    // single write from r0, engine done 40 cycles later
    cyc();
    r0_cmd = 4'h1; r0_din = 8'h78; r0_req = 1'b1;
    issue(0, 4'h1, 8'h78, 1, "wr");
    r0_din = 8'hFF;
    serve(0, 40, 0, 8'h00, "wr");
    finish_txn(0, "wr");

    // tie again after r0 was last served: r1 goes first
    cyc();
    r0_cmd = 4'h3; r0_din = 8'h11; r1_cmd = 4'h4; r1_din = 8'h22;
    r0_req = 1'b1; r1_req = 1'b1;
    issue(1, 4'h4, 8'h22, 1, "tie2a");
    serve(1, 3, 0, 8'h00, "tie2a");
    finish_txn(1, "tie2a");
    issue(0, 4'h3, 8'h11, 1, "tie2b");
    serve(0, 6, 0, 8'h00, "tie2b");
    finish_txn(0, "tie2b");

    // r1 locks four bytes while r0 keeps asking
    cyc();
    r1_cmd = 4'h1; r1_din = bytes[0]; r1_req = 1'b1; r1_lock = 1'b1;
    r0_cmd = 4'h3; r0_din = 8'hAA; r0_req = 1'b1;
    for (int j = 0; j < 4; j++) begin
      issue(1, 4'h1, bytes[j], 1, "lock");
      serve(1, int'($urandom_range(2, 8)), 0, 8'h00, "lock");
      cyc();
      if (j < 3) r1_din = bytes[j+1];
      else begin
        r1_req  = 1'b0;
        r1_lock = 1'b0;
      end
      #1;
      chk("lock_hold_busy", 32'(busy), 32'd1);
      chk("lock_r0_done", 32'(r0_done), 32'd0);
    end
    issue(0, 4'h3, 8'hAA, 2, "after_lock");
    serve(0, 5, 0, 8'h00, "after_lock");
    finish_txn(0, "after_lock");

    // read from r1, byte returned with done
    cyc();
    r1_cmd = 4'h2; r1_din = 8'h00; r1_req = 1'b1;
    issue(1, 4'h2, 8'h00, 1, "rd");
    serve(1, 7, 1, 8'h56, "rd");
    finish_txn(1, "rd");

    // watchdog on r0 with r1 queued behind it
    cyc();
    r0_cmd = 4'h5; r0_din = 8'h44; r0_req = 1'b1;
    issue(0, 4'h5, 8'h44, 1, "to");
    r1_cmd = 4'h6; r1_din = 8'h55; r1_req = 1'b1;
    serve(0, TO + 1, 0, 8'h00, "to");
    cyc();
    r0_req = 1'b0;
    #1;
    chk("to_idle", 32'(busy), 32'd0);
    chk("to_err_gone", 32'(er), 32'd0);
    issue(1, 4'h6, 8'h55, 1, "to_next");
    serve(1, 10, 0, 8'h00, "to_next");
    finish_txn(1, "to_next");

    // done on the final allowed cycle wins over the watchdog
    cyc();
    r0_cmd = 4'h7; r0_din = 8'h66; r0_req = 1'b1;
    issue(0, 4'h7, 8'h66, 1, "edge");
    serve(0, TO, 1, 8'h9E, "edge");
    finish_txn(0, "edge");

    // async reset while waiting on the engine
    cyc();
    r0_cmd = 4'h6; r0_din = 8'h33; r0_req = 1'b1;
    issue(0, 4'h6, 8'h33, 1, "arst");
    cyc(); cyc(); cyc();
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_req", 32'(m_trans_req), 32'd0);
    chk("arst_cmd", 32'(m_trans_cmd), 32'd0);
    chk("arst_din", 32'(m_wr_din), 32'd0);
    chk("arst_rdout", 32'(rd_dout), 32'd0);
    chk("arst_flags", 32'({dn, er, rd_vld, owner}), 32'd0);
    cyc();
    rst = 1'b0;
    r0_req = 1'b0;
    m_trans_done = 1'b1;
    cyc();
    m_trans_done = 1'b0;
    #1;
    chk("arst_late_done", 32'(dn), 32'd0);
    chk("arst_late_busy", 32'(busy), 32'd0);
    last_srv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1;
      chk("arst_noreq", 32'(m_trans_req), 32'd0);
    end

    // random traffic against the grant/handshake model
    for (int it = 0; it < 30; it++) begin
      bit [1:0]   pend;
      bit         w;
      bit         rd;
      int         k;
      int         r;
      logic [3:0] c0, c1;
      logic [7:0] d0, d1, dat;
      pend = 2'($urandom_range(1, 3));
      c0 = 4'($urandom); c1 = 4'($urandom);
      d0 = 8'($urandom); d1 = 8'($urandom);
      cyc();
      r0_cmd = c0; r0_din = d0; r1_cmd = c1; r1_din = d1;
      r0_req = pend[0]; r1_req = pend[1];
      while (pend != 2'b00) begin
        w = pick(pend, last_srv);
        issue(w, w ? c1 : c0, w ? d1 : d0, 1, "rnd");
        r = int'($urandom_range(0, 9));
        if (r == 0)      k = TO + 1;
        else if (r == 1) k = TO;
        else             k = int'($urandom_range(1, 25));
        rd  = 1'($urandom_range(0, 1));
        dat = 8'($urandom);
        serve(w, k, rd, dat, "rnd");
        finish_txn(w, "rnd");
        pend[w] = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one I2C byte engine (request/ack handshake: trans_req pulse, trans_cmd, wr_din in; trans_done, rd_dout, rd_dout_vld out) between two requesters.
- Requester 0 is the power-up register-table sequencer; requester 1 is the runtime control path (exposure/AWB/mirror writes and reads).
- Provides round-robin arbitration, lock-based multi-byte transaction ownership, and a per-byte timeout watchdog.
- Sits between the requesters and the I2C interface inside the camera configuration subsystem.

Parameters:
TIMEOUT_CYC, 24'd2_000_000, clk cycles allowed between engine request and trans_done before abort (40 ms at 50 MHz)
CMD_W, 4, width of the command/opcode field

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
r0_req  input  1  requester 0 byte request, level, held until r0_done or r0_err
r0_lock  input  1  requester 0 keeps ownership after the current byte
r0_cmd  input  CMD_W  requester 0 command code
r0_din  input  8  requester 0 write byte
r0_done  output  1  one-cycle byte-complete pulse to requester 0
r0_err  output  1  one-cycle timeout-abort pulse to requester 0
r1_req, r1_lock, r1_cmd, r1_din, r1_done, r1_err  same as r0_* for requester 1
rd_dout  output  8  read byte from last completed read, valid with rd_vld
rd_vld  output  1  one-cycle pulse, read byte valid; qualifies r*_done of the owner
owner  output  1  current or last owner index
busy  output  1  high in every state except IDLE
m_trans_req  output  1  one-cycle request pulse to the engine
m_trans_cmd  output  CMD_W  registered command to the engine
m_wr_din  output  8  registered write byte to the engine
m_trans_done  input  1  engine byte-complete pulse
m_rd_dout  input  8  engine read byte
m_rd_dout_vld  input  1  engine read-valid pulse

Behaviour:
- Reset state:
  - Outputs 0; m_trans_cmd, m_wr_din and rd_dout are 0.
  - State IDLE, owner=0, last_owner=1 so requester 0 wins the first tie.
  - Timeout counter 0.
- Reset asserted mid-transaction returns everything to the reset values immediately. No m_trans_req is issued afterwards until a new request.
- States:
  - IDLE: if exactly one req is high, grant it. If both are high, grant the requester that is not last_owner. Latch cmd/din into m_trans_cmd/m_wr_din and go to ISSUE.
  - ISSUE: m_trans_req=1 for exactly one cycle. Clear the counter and go to WAIT.
  - WAIT:
    - Counter increments each cycle.
    - m_rd_dout_vld: latch rd_dout; pulse rd_vld on the same cycle as the owner's done.
    - m_trans_done: go to HOLD and pulse the owner's done next cycle.
    - Counter == TIMEOUT_CYC-1 without done: pulse owner's err and go to IDLE. last_owner=owner; lock is discarded.
  - HOLD: one cycle that lets the owner drop req. If the owner's lock is high, go to LOCKED. Otherwise set last_owner=owner and go to IDLE.
  - LOCKED: the other requester is ignored. Owner req high: latch its cmd/din and go to ISSUE. Owner lock low (and req low): set last_owner=owner and go to IDLE.
- Latency: req rises in IDLE at cycle 0, then m_trans_req is high at cycle 1. Engine done at cycle t gives requester done at t+1. Earliest next m_trans_req from LOCKED is t+3.
- done/err go only to the owner. The non-owner's done and err stay 0.
- If trans_done and timeout coincide, done wins and err is not pulsed.
- An engine done or rd_vld outside WAIT is ignored.
- cmd/din are sampled only at grant; later changes have no effect on the byte in flight.
- m_trans_req never reasserts before trans_done or timeout. No two requests are outstanding.

Test Plan:
- Single write: r0_req with cmd=4'h1 and din=8'h78, engine done 40 cycles after the request -> one m_trans_req pulse with m_wr_din=8'h78, r0_done exactly 1 cycle after done, r1_done=0.
- Tie after reset: r0_req and r1_req rise together -> r0 served first, then r1. Repeat the tie -> r1 first this time (alternation).
- Locked 4-byte write: r1 holds lock for bytes 8'h78, 8'h30, 8'h08, 8'h82 while r0_req stays high -> all four bytes go to r1 in order, r0 is granted only after lock falls.
- Read: r1 read command, engine returns m_rd_dout=8'h56 with vld and done -> rd_dout=8'h56, rd_vld and r1_done pulse together.
- Timeout: TIMEOUT_CYC=100, no engine done -> r0_err pulses at cycle 100 after m_trans_req, busy=0 next cycle, pending r1 granted next.
- Async reset in WAIT: rst pulses -> all outputs 0 immediately, and a late engine done produces no done pulse.
